// File: rtl/alu.sv
// Registered MIPS R-type ALU subset (ADD, SUB, AND, OR, XOR, NOR, SRA, SRL).
// Result and status flags load together on every clock; unknown ops give zero.
module alu #(
  parameter int NB_DATA = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NB_DATA-1:0] dato_a,
  input  logic [NB_DATA-1:0] dato_b,
  input  logic [NB_DATA-1:0] op,
  output logic [NB_DATA-1:0] res,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_overflow
);

  localparam int NB_SH = $clog2(NB_DATA);
  localparam int MSB   = NB_DATA - 1;

  localparam logic [NB_DATA-1:0] OP_ADD = NB_DATA'(6'h20);
  localparam logic [NB_DATA-1:0] OP_SUB = NB_DATA'(6'h22);
  localparam logic [NB_DATA-1:0] OP_AND = NB_DATA'(6'h24);
  localparam logic [NB_DATA-1:0] OP_OR  = NB_DATA'(6'h25);
  localparam logic [NB_DATA-1:0] OP_XOR = NB_DATA'(6'h26);
  localparam logic [NB_DATA-1:0] OP_NOR = NB_DATA'(6'h27);
  localparam logic [NB_DATA-1:0] OP_SRA = NB_DATA'(6'h03);
  localparam logic [NB_DATA-1:0] OP_SRL = NB_DATA'(6'h02);

  logic [NB_DATA:0]          w_sum;
  logic [NB_DATA:0]          w_diff;
  logic                      w_sh_big;
  logic [NB_SH-1:0]          w_sh;
  logic signed [NB_DATA-1:0] w_sra;
  logic [NB_DATA-1:0]        w_srl;
  logic [NB_DATA-1:0]        w_res;
  logic                      w_carry;
  logic                      w_ovf;

  // Extra top bit of the difference is the unsigned borrow (a < b).
  assign w_sum  = {1'b0, dato_a} + {1'b0, dato_b};
  assign w_diff = {1'b0, dato_a} - {1'b0, dato_b};

  // The whole of dato_b is the shift amount; only small amounts reach the shifter.
  assign w_sh_big = (dato_b >= NB_DATA'(NB_DATA));
  assign w_sh     = dato_b[NB_SH-1:0];
  assign w_sra    = $signed(dato_a) >>> w_sh;
  assign w_srl    = dato_a >> w_sh;

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        w_res   = w_sum[MSB:0];
        w_carry = w_sum[NB_DATA];
        w_ovf   = (dato_a[MSB] == dato_b[MSB]) && (w_sum[MSB] != dato_a[MSB]);
      end
      OP_SUB: begin
        w_res   = w_diff[MSB:0];
        w_carry = w_diff[NB_DATA];
        w_ovf   = (dato_a[MSB] != dato_b[MSB]) && (w_diff[MSB] != dato_a[MSB]);
      end
      OP_AND: w_res = dato_a & dato_b;
      OP_OR:  w_res = dato_a | dato_b;
      OP_XOR: w_res = dato_a ^ dato_b;
      OP_NOR: w_res = ~(dato_a | dato_b);
      OP_SRA: begin
        if (w_sh_big) w_res = {NB_DATA{dato_a[MSB]}};
        else          w_res = w_sra;
      end
      OP_SRL: begin
        if (w_sh_big) w_res = '0;
        else          w_res = w_srl;
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res        <= '0;
      o_zero     <= 1'b1;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      res        <= w_res;
      o_zero     <= (w_res == '0);
      o_carry    <= w_carry;
      o_overflow <= w_ovf;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed and random checks for the registered ALU at NB_DATA = 8.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] dato_a;
  logic [7:0] dato_b;
  logic [7:0] op;
  logic [7:0] res;
  logic       o_zero;
  logic       o_carry;
  logic       o_overflow;

  int checks = 0;
  int errors = 0;

  alu #(.NB_DATA(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dato_a     (dato_a),
    .dato_b     (dato_b),
    .op         (op),
    .res        (res),
    .o_zero     (o_zero),
    .o_carry    (o_carry),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {res, zero, carry, overflow}, computed with plain integer arithmetic.
  function automatic logic [10:0] model(input int a, input int b, input int f);
    int r;
    int sa;
    bit c;
    bit v;
    r = 0; c = 0; v = 0;
    sa = (a >= 128) ? a - 256 : a;
    case (f)
      'h20: begin
        r = (a + b) % 256;
        c = (a + b) > 255;
        v = ((a >= 128) == (b >= 128)) && ((r >= 128) != (a >= 128));
      end
      'h22: begin
        r = (a - b + 256) % 256;
        c = a < b;
        v = ((a >= 128) != (b >= 128)) && ((r >= 128) != (a >= 128));
      end
      'h24: r = a & b;
      'h25: r = a | b;
      'h26: r = a ^ b;
      'h27: r = 255 - (a | b);
      'h03: r = (b >= 8) ? ((a >= 128) ? 255 : 0) : ((sa >>> b) & 255);
      'h02: r = (b >= 8) ? 0 : (a >> b);
      default: r = 0;
    endcase
    return {r[7:0], (r == 0), c, v};
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f);
    @(negedge clk);
    dato_a = a;
    dato_b = b;
    op     = f;
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    rst_n = 1'b0; dato_a = 8'h00; dato_b = 8'h00; op = 8'h20;
    repeat (2) @(posedge clk);
    #1;
    obs = {res, o_zero, o_carry, o_overflow};
    checks++;
    if (obs !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold got=%h want=%h", obs, {8'h00, 3'b100});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    obs = {res, o_zero, o_carry, o_overflow};
    checks++;
    if (obs !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", obs, {8'h00, 3'b100});
    end
  endtask

  task automatic test_add_sub();
    logic [7:0] va [4] = '{8'h7F, 8'h05, 8'hFF, 8'h80};
    logic [7:0] vb [4] = '{8'h01, 8'h07, 8'h01, 8'h01};
    logic [7:0] vf [4] = '{8'h20, 8'h22, 8'h20, 8'h22};
    logic [10:0] ve [4] = '{{8'h80, 3'b001}, {8'hFE, 3'b010},
                            {8'h00, 3'b110}, {8'h7F, 3'b001}};
    logic [10:0] obs;
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], vf[i]);
      @(posedge clk); #1;
      obs = {res, o_zero, o_carry, o_overflow};
      checks++;
      if (obs !== ve[i]) begin
        errors++;
        $display("FAIL add_sub[%0d] got=%h want=%h", i, obs, ve[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [7:0] vf [4] = '{8'h24, 8'h25, 8'h26, 8'h27};
    logic [7:0] ve [4] = '{8'h05, 8'hAF, 8'hAA, 8'h50};
    logic [10:0] obs;
    for (int i = 0; i < 4; i++) begin
      drive(8'hA5, 8'h0F, vf[i]);
      @(posedge clk); #1;
      obs = {res, o_zero, o_carry, o_overflow};
      checks++;
      if (obs !== {ve[i], 3'b000}) begin
        errors++;
        $display("FAIL logic[%0d] got=%h want=%h", i, obs, {ve[i], 3'b000});
      end
    end
  endtask

  task automatic test_shift();
    logic [7:0] va [6] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h40, 8'hC3};
    logic [7:0] vb [6] = '{8'h03, 8'h03, 8'h09, 8'h09, 8'h08, 8'hFF};
    logic [7:0] vf [6] = '{8'h03, 8'h02, 8'h03, 8'h02, 8'h03, 8'h03};
    logic [10:0] ve [6] = '{{8'hF0, 3'b000}, {8'h10, 3'b000}, {8'hFF, 3'b000},
                            {8'h00, 3'b100}, {8'h00, 3'b100}, {8'hFF, 3'b000}};
    logic [10:0] obs;
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vf[i]);
      @(posedge clk); #1;
      obs = {res, o_zero, o_carry, o_overflow};
      checks++;
      if (obs !== ve[i]) begin
        errors++;
        $display("FAIL shift[%0d] got=%h want=%h", i, obs, ve[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] vf [3] = '{8'h21, 8'h60, 8'hA0};
    logic [10:0] obs;
    for (int i = 0; i < 3; i++) begin
      drive(8'h12, 8'h34, vf[i]);
      @(posedge clk); #1;
      obs = {res, o_zero, o_carry, o_overflow};
      checks++;
      if (obs !== {8'h00, 3'b100}) begin
        errors++;
        $display("FAIL illegal op=%h got=%h want=%h", vf[i], obs, {8'h00, 3'b100});
      end
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] obs;
    drive(8'h7F, 8'h01, 8'h20);
    @(posedge clk); #1;
    obs = {res, o_zero, o_carry, o_overflow};
    checks++;
    if (obs !== {8'h80, 3'b001}) begin
      errors++;
      $display("FAIL pre_async got=%h want=%h", obs, {8'h80, 3'b001});
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {res, o_zero, o_carry, o_overflow};
    checks++;
    if (obs !== {8'h00, 3'b100}) begin
      errors++;
      $display("FAIL async_assert got=%h want=%h", obs, {8'h00, 3'b100});
    end
    @(posedge clk); #1;
    obs = {res, o_zero, o_carry, o_overflow};
    checks++;
    if (obs !== {8'h00, 3'b100}) begin
      errors++;
      $display("FAIL async_hold got=%h want=%h", obs, {8'h00, 3'b100});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    logic [7:0] a;
    logic [7:0] b;
    logic [10:0] exp;
    logic [10:0] obs;
    for (int i = 0; i < 240; i++) begin
      a = 8'($urandom_range(0, 255));
      b = (ops[i % 8] == 8'h03 || ops[i % 8] == 8'h02) && (i % 3 != 0)
          ? 8'($urandom_range(0, 10)) : 8'($urandom_range(0, 255));
      exp = model(int'(a), int'(b), int'(ops[i % 8]));
      drive(a, b, ops[i % 8]);
      @(posedge clk); #1;
      obs = {res, o_zero, o_carry, o_overflow};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random[%0d] a=%h b=%h op=%h got=%h want=%h",
                 i, a, b, ops[i % 8], obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_shift();
    test_illegal();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
